// File: rtl/tlb_pkg.sv
// Shared definitions for the MIPS32-style TLB: CP0 register field positions,
// per-page attribute struct and TLB exception codes.
package tlb_pkg;

    // EntryHi layout: VPN2 in [31:13], ASID in the low bits.
    localparam int VPN2_HI    = 31;
    localparam int VPN2_LO    = 13;
    localparam int VPN2_W     = VPN2_HI - VPN2_LO + 1;
    localparam int HI_ASID_LO = 0;

    // EntryLo layout: PFN from bit 6 upward, then C/D/V/G.
    localparam int LO_PFN_LO  = 6;
    localparam int LO_C_HI    = 5;
    localparam int LO_C_LO    = 3;
    localparam int LO_D       = 2;
    localparam int LO_V       = 1;
    localparam int LO_G       = 0;

    // Exception codes raised on the translation paths.
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;

    // Attributes of one page (even or odd half) of an entry.
    typedef struct packed {
        logic [2:0] c;
        logic       d;
        logic       v;
    } tlb_flags_t;

    // Extract the page attributes from a CP0 EntryLo word.
    function automatic tlb_flags_t lo_flags(input logic [31:0] lo);
        tlb_flags_t f;
        f.c = lo[LO_C_HI:LO_C_LO];
        f.d = lo[LO_D];
        f.v = lo[LO_V];
        return f;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully-associative comparator bank: finds the lowest-index entry matching
// (vpn2, asid) and returns the even or odd page selected by `odd`.
module tlb_match
    import tlb_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int ASID_W      = 8,
    parameter int PFN_W       = 20
) (
    input  logic [VPN2_W-1:0] vpn2,
    input  logic [ASID_W-1:0] asid,
    input  logic              odd,
    input  logic              ent_valid [NUM_ENTRIES],
    input  logic [VPN2_W-1:0] ent_vpn2  [NUM_ENTRIES],
    input  logic [ASID_W-1:0] ent_asid  [NUM_ENTRIES],
    input  logic              ent_g     [NUM_ENTRIES],
    input  logic [PFN_W-1:0]  ent_pfn0  [NUM_ENTRIES],
    input  logic [PFN_W-1:0]  ent_pfn1  [NUM_ENTRIES],
    input  tlb_flags_t        ent_fl0   [NUM_ENTRIES],
    input  tlb_flags_t        ent_fl1   [NUM_ENTRIES],
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [PFN_W-1:0]  sel_pfn,
    output tlb_flags_t        sel_flags
);

    logic [NUM_ENTRIES-1:0] match;

    // Per-entry compare: valid, same VPN2, and global or same ASID.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match[i] = ent_valid[i] && (ent_vpn2[i] == vpn2) &&
                       (ent_g[i] || (ent_asid[i] == asid));
        end
    end

    // Priority encoder: scanning downward leaves the lowest hit in place.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign sel_pfn   = odd ? ent_pfn1[hit_idx] : ent_pfn0[hit_idx];
    assign sel_flags = odd ? ent_fl1[hit_idx]  : ent_fl0[hit_idx];

endmodule

// File: rtl/tlb_unit.sv
// Registered MIPS32-style TLB with independent instruction and data lookup
// ports, CP0 TLBWI/TLBWR/TLBP/TLBR support and a Random/Wired counter.
module tlb_unit
    import tlb_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int ASID_W      = 8,
    parameter int PA_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_vaddr,
    output logic              i_valid,
    output logic [PA_W-1:0]   i_paddr,
    output logic              i_miss,
    output logic              i_inv,
    input  logic              d_req,
    input  logic [31:0]       d_vaddr,
    input  logic              d_store,
    output logic              d_valid,
    output logic [PA_W-1:0]   d_paddr,
    output logic              d_miss,
    output logic              d_inv,
    output logic              d_mod,
    input  logic [ASID_W-1:0] asid_i,
    input  logic [31:0]       entryhi_i,
    input  logic [31:0]       entrylo0_i,
    input  logic [31:0]       entrylo1_i,
    input  logic [IDX_W-1:0]  index_i,
    input  logic [IDX_W-1:0]  wired_i,
    input  logic              wired_we,
    input  logic              tlbwi,
    input  logic              tlbwr,
    input  logic              tlbp,
    input  logic              tlbr,
    input  logic              flush,
    output logic [IDX_W-1:0]  random_o,
    output logic              probe_valid,
    output logic              probe_miss,
    output logic [IDX_W-1:0]  probe_index,
    output logic              rd_valid,
    output logic [31:0]       rd_entryhi,
    output logic [31:0]       rd_entrylo0,
    output logic [31:0]       rd_entrylo1
);

    localparam int               PFN_W   = PA_W - 12;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_ENTRIES - 1);

    // Entry storage, one array per field so the comparators see it flat.
    logic              ent_valid [NUM_ENTRIES];
    logic [VPN2_W-1:0] ent_vpn2  [NUM_ENTRIES];
    logic [ASID_W-1:0] ent_asid  [NUM_ENTRIES];
    logic              ent_g     [NUM_ENTRIES];
    logic [PFN_W-1:0]  ent_pfn0  [NUM_ENTRIES];
    logic [PFN_W-1:0]  ent_pfn1  [NUM_ENTRIES];
    tlb_flags_t        ent_fl0   [NUM_ENTRIES];
    tlb_flags_t        ent_fl1   [NUM_ENTRIES];

    logic [IDX_W-1:0]  random_q;
    logic [IDX_W-1:0]  wired_q;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;

    logic              i_hit, d_hit, p_hit;
    logic [IDX_W-1:0]  i_idx, d_idx, p_idx;
    logic [PFN_W-1:0]  i_pfn, d_pfn, p_pfn;
    tlb_flags_t        i_fl, d_fl, p_fl;

    logic [PA_W-1:0]   i_paddr_n, d_paddr_n;
    logic              i_miss_n, i_inv_n;
    logic              d_miss_n, d_inv_n, d_mod_n;

    // CP0 EntryLo image of one page of an entry.
    function automatic logic [31:0] pack_lo(input logic [PFN_W-1:0] pfn,
                                            input tlb_flags_t f,
                                            input logic g);
        return (32'(pfn) << LO_PFN_LO) | {26'b0, f.c, f.d, f.v, g};
    endfunction

    tlb_match #(
        .NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W), .PFN_W(PFN_W)
    ) u_match_i (
        .vpn2(i_vaddr[VPN2_HI:VPN2_LO]), .asid(asid_i), .odd(i_vaddr[12]),
        .ent_valid(ent_valid), .ent_vpn2(ent_vpn2), .ent_asid(ent_asid),
        .ent_g(ent_g), .ent_pfn0(ent_pfn0), .ent_pfn1(ent_pfn1),
        .ent_fl0(ent_fl0), .ent_fl1(ent_fl1),
        .hit(i_hit), .hit_idx(i_idx), .sel_pfn(i_pfn), .sel_flags(i_fl)
    );

    tlb_match #(
        .NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W), .PFN_W(PFN_W)
    ) u_match_d (
        .vpn2(d_vaddr[VPN2_HI:VPN2_LO]), .asid(asid_i), .odd(d_vaddr[12]),
        .ent_valid(ent_valid), .ent_vpn2(ent_vpn2), .ent_asid(ent_asid),
        .ent_g(ent_g), .ent_pfn0(ent_pfn0), .ent_pfn1(ent_pfn1),
        .ent_fl0(ent_fl0), .ent_fl1(ent_fl1),
        .hit(d_hit), .hit_idx(d_idx), .sel_pfn(d_pfn), .sel_flags(d_fl)
    );

    // The probe bank only needs hit/index; the page select is don't-care.
    tlb_match #(
        .NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W), .PFN_W(PFN_W)
    ) u_match_p (
        .vpn2(entryhi_i[VPN2_HI:VPN2_LO]),
        .asid(entryhi_i[HI_ASID_LO +: ASID_W]), .odd(1'b0),
        .ent_valid(ent_valid), .ent_vpn2(ent_vpn2), .ent_asid(ent_asid),
        .ent_g(ent_g), .ent_pfn0(ent_pfn0), .ent_pfn1(ent_pfn1),
        .ent_fl0(ent_fl0), .ent_fl1(ent_fl1),
        .hit(p_hit), .hit_idx(p_idx), .sel_pfn(p_pfn), .sel_flags(p_fl)
    );

    // Instruction translation: kseg (bit 31 set) bypasses the TLB.
    always_comb begin
        i_paddr_n = '0;
        i_miss_n  = 1'b0;
        i_inv_n   = 1'b0;
        if (i_vaddr[31]) begin
            i_paddr_n = i_vaddr[PA_W-1:0];
        end else if (!i_hit) begin
            i_miss_n = 1'b1;
        end else if (!i_fl.v) begin
            i_inv_n = 1'b1;
        end else begin
            i_paddr_n = {i_pfn, i_vaddr[11:0]};
        end
    end

    // Data translation: miss beats invalid beats modified.
    always_comb begin
        d_paddr_n = '0;
        d_miss_n  = 1'b0;
        d_inv_n   = 1'b0;
        d_mod_n   = 1'b0;
        if (d_vaddr[31]) begin
            d_paddr_n = d_vaddr[PA_W-1:0];
        end else if (!d_hit) begin
            d_miss_n = 1'b1;
        end else if (!d_fl.v) begin
            d_inv_n = 1'b1;
        end else if (d_store && !d_fl.d) begin
            d_mod_n = 1'b1;
        end else begin
            d_paddr_n = {d_pfn, d_vaddr[11:0]};
        end
    end

    // Lookup result registers; everything is zero on cycles without a request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_valid <= 1'b0;
            i_paddr <= '0;
            i_miss  <= 1'b0;
            i_inv   <= 1'b0;
            d_valid <= 1'b0;
            d_paddr <= '0;
            d_miss  <= 1'b0;
            d_inv   <= 1'b0;
            d_mod   <= 1'b0;
        end else begin
            i_valid <= i_req;
            i_paddr <= i_req ? i_paddr_n : '0;
            i_miss  <= i_req & i_miss_n;
            i_inv   <= i_req & i_inv_n;
            d_valid <= d_req;
            d_paddr <= d_req ? d_paddr_n : '0;
            d_miss  <= d_req & d_miss_n;
            d_inv   <= d_req & d_inv_n;
            d_mod   <= d_req & d_mod_n;
        end
    end

    // Flush suppresses any write issued in the same cycle.
    assign wr_en  = (tlbwi | tlbwr) & ~flush;
    assign wr_idx = tlbwr ? random_q : index_i;

    // Entry array update: flush invalidates all, TLBWI/TLBWR write one entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_valid[i] <= 1'b0;
                ent_vpn2[i]  <= '0;
                ent_asid[i]  <= '0;
                ent_g[i]     <= 1'b0;
                ent_pfn0[i]  <= '0;
                ent_pfn1[i]  <= '0;
                ent_fl0[i]   <= '0;
                ent_fl1[i]   <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_valid[i] <= 1'b0;
            end
        end else if (wr_en) begin
            ent_valid[wr_idx] <= 1'b1;
            ent_vpn2[wr_idx]  <= entryhi_i[VPN2_HI:VPN2_LO];
            ent_asid[wr_idx]  <= entryhi_i[HI_ASID_LO +: ASID_W];
            ent_g[wr_idx]     <= entrylo0_i[LO_G] & entrylo1_i[LO_G];
            ent_pfn0[wr_idx]  <= entrylo0_i[PA_W-7:LO_PFN_LO];
            ent_pfn1[wr_idx]  <= entrylo1_i[PA_W-7:LO_PFN_LO];
            ent_fl0[wr_idx]   <= lo_flags(entrylo0_i);
            ent_fl1[wr_idx]   <= lo_flags(entrylo1_i);
        end
    end

    // Random walks down to Wired, then reloads the top index; Wired writes reload too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random_q <= TOP_IDX;
            wired_q  <= '0;
        end else if (wired_we) begin
            wired_q  <= wired_i;
            random_q <= TOP_IDX;
        end else if (random_q <= wired_q) begin
            random_q <= TOP_IDX;
        end else begin
            random_q <= random_q - 1'b1;
        end
    end

    assign random_o = random_q;

    // TLBP and TLBR results, each valid for one cycle after the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            probe_valid <= 1'b0;
            probe_miss  <= 1'b0;
            probe_index <= '0;
            rd_valid    <= 1'b0;
            rd_entryhi  <= '0;
            rd_entrylo0 <= '0;
            rd_entrylo1 <= '0;
        end else begin
            probe_valid <= tlbp;
            probe_miss  <= tlbp & ~p_hit;
            probe_index <= (tlbp && p_hit) ? p_idx : '0;
            rd_valid    <= tlbr;
            if (tlbr) begin
                rd_entryhi  <= {ent_vpn2[index_i], 13'b0} | 32'(ent_asid[index_i]);
                rd_entrylo0 <= pack_lo(ent_pfn0[index_i], ent_fl0[index_i], ent_g[index_i]);
                rd_entrylo1 <= pack_lo(ent_pfn1[index_i], ent_fl1[index_i], ent_g[index_i]);
            end else begin
                rd_entryhi  <= '0;
                rd_entrylo0 <= '0;
                rd_entrylo1 <= '0;
            end
        end
    end

    // TLB instruction strobes are mutually exclusive.
    a_strobe_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({tlbwi, tlbwr, tlbp, tlbr}));

endmodule

// File: tb/tb_tlb_unit.sv
// Self-checking bench for tlb_unit: lookup results go through an expected
// queue; CP0 operations and the Random counter are checked inline.
module tb_tlb_unit;

    localparam int IDX_W = 4;
    localparam int W     = 36;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_req = 1'b0;
    logic [31:0]      i_vaddr = '0;
    logic             i_valid;
    logic [31:0]      i_paddr;
    logic             i_miss, i_inv;
    logic             d_req = 1'b0;
    logic [31:0]      d_vaddr = '0;
    logic             d_store = 1'b0;
    logic             d_valid;
    logic [31:0]      d_paddr;
    logic             d_miss, d_inv, d_mod;
    logic [7:0]       asid_i = 8'd5;
    logic [31:0]      entryhi_i = '0;
    logic [31:0]      entrylo0_i = '0;
    logic [31:0]      entrylo1_i = '0;
    logic [IDX_W-1:0] index_i = '0;
    logic [IDX_W-1:0] wired_i = '0;
    logic             wired_we = 1'b0;
    logic             tlbwi = 1'b0, tlbwr = 1'b0, tlbp = 1'b0, tlbr = 1'b0;
    logic             flush = 1'b0;
    logic [IDX_W-1:0] random_o;
    logic             probe_valid, probe_miss;
    logic [IDX_W-1:0] probe_index;
    logic             rd_valid;
    logic [31:0]      rd_entryhi, rd_entrylo0, rd_entrylo1;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v, obs_v;
    int           n_vec = 0;
    int           n_err = 0;

    tlb_unit dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_valid(i_valid), .i_paddr(i_paddr),
        .i_miss(i_miss), .i_inv(i_inv),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_store(d_store), .d_valid(d_valid),
        .d_paddr(d_paddr), .d_miss(d_miss), .d_inv(d_inv), .d_mod(d_mod),
        .asid_i(asid_i), .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i),
        .entrylo1_i(entrylo1_i), .index_i(index_i), .wired_i(wired_i),
        .wired_we(wired_we), .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .tlbr(tlbr),
        .flush(flush), .random_o(random_o), .probe_valid(probe_valid),
        .probe_miss(probe_miss), .probe_index(probe_index), .rd_valid(rd_valid),
        .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic v, input logic [31:0] pa,
                                        input logic miss, input logic inv,
                                        input logic md);
        return {v, pa, miss, inv, md};
    endfunction

    function automatic logic [W-1:0] d_obs();
        return {d_valid, d_paddr, d_miss, d_inv, d_mod};
    endfunction

    function automatic logic [W-1:0] i_obs();
        return {i_valid, i_paddr, i_miss, i_inv, 1'b0};
    endfunction

    // Drivers: inputs change on the falling edge, outputs are read on the next one.
    task automatic wr_entry(input logic [IDX_W-1:0] idx, input logic [31:0] hi,
                            input logic [31:0] lo0, input logic [31:0] lo1);
        @(negedge clk);
        index_i = idx; entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1;
        tlbwi = 1'b1;
        @(negedge clk);
        tlbwi = 1'b0;
    endtask

    task automatic drive_d(input logic [31:0] va, input logic st);
        @(negedge clk);
        d_vaddr = va; d_store = st; d_req = 1'b1;
        @(negedge clk);
        d_req = 1'b0; d_store = 1'b0;
    endtask

    task automatic drive_i(input logic [31:0] va);
        @(negedge clk);
        i_vaddr = va; i_req = 1'b1;
        @(negedge clk);
        i_req = 1'b0;
    endtask

    task automatic drive_probe(input logic [31:0] hi);
        @(negedge clk);
        entryhi_i = hi; tlbp = 1'b1;
        @(negedge clk);
        tlbp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        obs_v = d_obs() | i_obs();
        n_vec++;
        if ({obs_v, probe_valid, probe_miss, probe_index, rd_valid,
             rd_entryhi, rd_entrylo0, rd_entrylo1} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: some output nonzero (lookup bits %h)", obs_v);
        end
        n_vec++;
        if (random_o !== 4'd15) begin
            n_err++;
            $display("FAIL reset_random: got %0d want 15", random_o);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b0));
        drive_d(32'h0040_1000, 1'b0);
        obs_v = d_obs();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL reset_miss: got %h want %h", obs_v, exp_v);
        end
        @(negedge clk);
        n_vec++;
        if (d_obs() !== '0) begin
            n_err++;
            $display("FAIL idle_zero: got %h want 0", d_obs());
        end
    endtask

    task automatic test_lookup();
        logic [31:0] va [3] = '{32'h0040_0ABC, 32'h0040_1ABC, 32'h0040_0ABC};
        logic        st [3] = '{1'b0, 1'b0, 1'b1};
        exp_q.push_back(mk(1'b1, 32'h1234_5ABC, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h1234_5ABC, 1'b0, 1'b0, 1'b0));
        wr_entry(4'd3, 32'h0040_0005, 32'h0048_D146, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive_d(va[k], st[k]);
            obs_v = d_obs();
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL lookup_d[%0d]: got %h want %h", k, obs_v, exp_v);
            end
        end
        exp_q.push_back(mk(1'b1, 32'h1234_5100, 1'b0, 1'b0, 1'b0));
        drive_i(32'h0040_0100);
        obs_v = i_obs();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL lookup_i: got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_modified();
        logic [31:0] va [3] = '{32'h0040_0000, 32'h0040_0000, 32'h0040_1000};
        logic        st [3] = '{1'b1, 1'b0, 1'b1};
        exp_q.push_back(mk(1'b1, 32'h0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(1'b1, 32'h1234_5000, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h0, 1'b0, 1'b1, 1'b0));
        wr_entry(4'd3, 32'h0040_0005, 32'h0048_D142, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive_d(va[k], st[k]);
            obs_v = d_obs();
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL modified[%0d]: got %h want %h", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_asid();
        asid_i = 8'd6;
        exp_q.push_back(mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b0));
        drive_d(32'h0040_0000, 1'b0);
        obs_v = d_obs();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL asid_miss: got %h want %h", obs_v, exp_v);
        end
        wr_entry(4'd3, 32'h0040_0005, 32'h0048_D147, 32'h1);
        exp_q.push_back(mk(1'b1, 32'h1234_5000, 1'b0, 1'b0, 1'b0));
        drive_d(32'h0040_0000, 1'b0);
        obs_v = d_obs();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL asid_global: got %h want %h", obs_v, exp_v);
        end
        asid_i = 8'd5;
    endtask

    task automatic test_random();
        logic [IDX_W-1:0] model;
        @(negedge clk);
        wired_i = 4'd4; wired_we = 1'b1;
        @(negedge clk);
        wired_we = 1'b0;
        model = 4'd15;
        n_vec++;
        if (random_o !== model) begin
            n_err++;
            $display("FAIL random_load: got %0d want %0d", random_o, model);
        end
        for (int k = 0; k < 18; k++) begin
            model = (model <= 4'd4) ? 4'd15 : model - 4'd1;
            @(negedge clk);
            tlbwr = 1'b0;
            n_vec++;
            if (random_o !== model) begin
                n_err++;
                $display("FAIL random_step[%0d]: got %0d want %0d", k, random_o, model);
            end
            if (k > 11 && model == 4'd9) begin
                entryhi_i = 32'h1234_A007; entrylo0_i = 32'h0001_DDDF;
                entrylo1_i = 32'h0002_2203; tlbwr = 1'b1;
            end
        end
        @(negedge clk);
        tlbwr = 1'b0;
        index_i = 4'd9; tlbr = 1'b1;
        @(negedge clk);
        tlbr = 1'b0;
        n_vec++;
        if ({rd_valid, rd_entryhi, rd_entrylo0, rd_entrylo1} !==
            {1'b1, 32'h1234_A007, 32'h0001_DDDF, 32'h0002_2203}) begin
            n_err++;
            $display("FAIL tlbwr_read: got v=%b hi=%h lo0=%h lo1=%h want v=1 hi=1234a007 lo0=0001dddf lo1=00022203",
                     rd_valid, rd_entryhi, rd_entrylo0, rd_entrylo1);
        end
    endtask

    task automatic test_probe();
        wr_entry(4'd2, 32'h0080_0005, 32'h2, 32'h2);
        wr_entry(4'd7, 32'h0080_0005, 32'h2, 32'h2);
        drive_probe(32'h0080_0005);
        n_vec++;
        if ({probe_valid, probe_miss, probe_index} !== {1'b1, 1'b0, 4'd2}) begin
            n_err++;
            $display("FAIL probe_prio: got v=%b m=%b idx=%0d want v=1 m=0 idx=2",
                     probe_valid, probe_miss, probe_index);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive_probe(32'h0080_0005);
        n_vec++;
        if ({probe_valid, probe_miss, probe_index} !== {1'b1, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL probe_flush: got v=%b m=%b idx=%0d want v=1 m=1 idx=0",
                     probe_valid, probe_miss, probe_index);
        end
        exp_q.push_back(mk(1'b1, 32'h8000_1000, 1'b0, 1'b0, 1'b0));
        drive_i(32'h8000_1000);
        obs_v = i_obs();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL unmapped_i: got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_same_cycle();
        // Write and lookup in one cycle: old (empty) contents, then the new entry.
        exp_q.push_back(mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h1234_5010, 1'b0, 1'b0, 1'b0));
        // Flush and lookup in one cycle: old contents hit, then miss.
        exp_q.push_back(mk(1'b1, 32'h1234_5010, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b0));
        // Flush together with TLBWI: the write is dropped.
        exp_q.push_back(mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        index_i = 4'd5; entryhi_i = 32'h00C0_0005;
        entrylo0_i = 32'h0048_D146; entrylo1_i = 32'h0;
        tlbwi = 1'b1; d_vaddr = 32'h00C0_0010; d_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tlbwi = 1'b0; flush = 1'b0; d_req = 1'b0;
            obs_v = d_obs();
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL same_cycle[%0d]: got %h want %h", k, obs_v, exp_v);
            end
            case (k)
                0: begin d_req = 1'b1; end
                1: begin d_req = 1'b1; flush = 1'b1; end
                2: begin d_req = 1'b1; end
                3: begin
                    index_i = 4'd6; entryhi_i = 32'h00E0_0005;
                    tlbwi = 1'b1; flush = 1'b1;
                end
                default: ;
            endcase
            if (k == 3) begin
                @(negedge clk);
                tlbwi = 1'b0; flush = 1'b0;
                d_vaddr = 32'h00E0_0000; d_req = 1'b1;
            end
        end
    endtask

    task automatic test_back_to_back();
        wr_entry(4'd4, 32'h0040_0005, 32'h0048_D146, 32'h0);
        exp_q.push_back(mk(1'b1, 32'h1234_5020, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h9000_0004, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        i_vaddr = 32'h0040_0020; i_req = 1'b1;
        d_vaddr = 32'h9000_0004; d_store = 1'b1; d_req = 1'b1;
        @(negedge clk);
        i_vaddr = 32'h0040_1020;
        d_vaddr = 32'h0040_0040; d_store = 1'b1;
        entrylo0_i = 32'h0;
        for (int k = 0; k < 2; k++) begin
            obs_v = i_obs();
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL dual_i[%0d]: got %h want %h", k, obs_v, exp_v);
            end
            obs_v = d_obs();
            exp_v = exp_q.pop_front();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL dual_d[%0d]: got %h want %h", k, obs_v, exp_v);
            end
            if (k == 0) begin
                // Second pair: odd page of entry 4 is invalid; store to its clean even page.
                wr_entry(4'd4, 32'h0040_0005, 32'h0048_D142, 32'h0);
                @(negedge clk);
                i_vaddr = 32'h0040_1020; i_req = 1'b1;
                d_vaddr = 32'h0040_0040; d_store = 1'b1; d_req = 1'b1;
                @(negedge clk);
            end
            i_req = 1'b0; d_req = 1'b0; d_store = 1'b0;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: %0d expected results never produced", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_modified();
        test_asid();
        test_random();
        test_probe();
        test_same_cycle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the sequence above never completes.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
